// File: rtl/mod_n_counter_pkg.sv
// Shared types for the modulo-N up/down counter: FSM state encoding and
// wrap/saturate mode constants.
package mod_n_counter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_DOWN   = 3'd2,
    S_SAT_HI = 3'd3,
    S_SAT_LO = 3'd4
  } state_t;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic logic is_sat_state(input state_t s);
    return (s == S_SAT_HI) || (s == S_SAT_LO);
  endfunction

endpackage

// File: rtl/mod_n_step.sv
// Combinational next-count calculation for one count step: returns the next
// value, whether the step wrapped, and whether it was clamped at a bound.
module mod_n_step
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             up_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o,
  output logic             clamp_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    next_o  = q_i;
    wrap_o  = 1'b0;
    clamp_o = 1'b0;
    if (up_i) begin
      if (q_i < max_i) begin
        next_o = q_i + ONE;
      end else if (mode_i == MODE_WRAP) begin
        next_o = '0;
        wrap_o = 1'b1;
      end else begin
        next_o  = max_i;
        clamp_o = 1'b1;
      end
    end else begin
      // A count above the terminal value (i_max lowered at runtime) snaps
      // down to it without counting as a wrap.
      if (q_i > max_i) begin
        next_o = max_i;
      end else if (q_i != '0) begin
        next_o = q_i - ONE;
      end else if (mode_i == MODE_WRAP) begin
        next_o = max_i;
        wrap_o = 1'b1;
      end else begin
        next_o  = '0;
        clamp_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with programmable terminal value, clear/load,
// wrap or saturate mode, registered terminal-count pulse and saturation flag.
module mod_n_updown_counter
  import mod_n_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up_down,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_tc,
  output logic             o_sat,
  output logic             o_dir,
  output logic [2:0]       o_state
);

  // Handshake-free block: every input is sampled on each rising edge and its
  // effect is visible on the registered outputs one cycle later.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] step_next;
  logic             step_wrap;
  logic             step_clamp;
  logic [WIDTH-1:0] load_clamped;
  logic             state_legal;

  mod_n_step #(.WIDTH(WIDTH)) u_step (
    .q_i     (q_q),
    .max_i   (i_max),
    .up_i    (i_up_down),
    .mode_i  (i_mode),
    .next_o  (step_next),
    .wrap_o  (step_wrap),
    .clamp_o (step_clamp)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      tc_q    <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    load_clamped = (i_load_val > i_max) ? i_max : i_load_val;
    case (state_q)
      S_IDLE, S_UP, S_DOWN, S_SAT_HI, S_SAT_LO: state_legal = 1'b1;
      default:                                  state_legal = 1'b0;
    endcase

    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    dir_d   = dir_q;
    if (i_clear) begin
      q_d     = '0;
      state_d = S_IDLE;
    end else if (i_load) begin
      q_d     = load_clamped;
      state_d = S_IDLE;
    end else if (!state_legal) begin
      state_d = S_IDLE;
    end else if (i_en) begin
      q_d   = step_next;
      tc_d  = step_wrap;
      dir_d = i_up_down;
      if (step_clamp) state_d = i_up_down ? S_SAT_HI : S_SAT_LO;
      else            state_d = i_up_down ? S_UP : S_DOWN;
    end else if (state_q == S_UP || state_q == S_DOWN) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    o_Q     = q_q;
    o_tc    = tc_q;
    o_dir   = dir_q;
    o_sat   = is_sat_state(state_q);
    o_state = state_q;
  end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed-vector bench for mod_n_updown_counter (WIDTH=4).
module tb_mod_n_updown_counter;
  import mod_n_counter_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         up_down;
  logic         mode;
  logic [W-1:0] max_v;
  logic [W-1:0] q;
  logic         tc;
  logic         sat;
  logic         dir;
  logic [2:0]   state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] up_exp [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [W-1:0] sat_q_exp [4] = '{4'd8, 4'd9, 4'd9, 4'd9};
  logic         sat_f_exp [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  mod_n_updown_counter #(.WIDTH(W)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clear    (clear),
    .i_load     (load),
    .i_load_val (load_val),
    .i_en       (en),
    .i_up_down  (up_down),
    .i_mode     (mode),
    .i_max      (max_v),
    .o_Q        (q),
    .o_tc       (tc),
    .o_sat      (sat),
    .o_dir      (dir),
    .o_state    (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0; en = 1'b0;
    up_down = 1'b1; mode = MODE_WRAP; max_v = 4'd9;
    #22;
    n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d want 0", q); end
    n_cmp++; if ({tc, sat, dir} !== 3'b001) begin n_fail++; $display("FAIL reset_flags tc/sat/dir: got %b want 001", {tc, sat, dir}); end
    n_cmp++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
  endtask

  task automatic test_wrap_up();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; up_down = 1'b1; mode = MODE_WRAP; max_v = 4'd9;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++; if (q !== up_exp[i]) begin n_fail++; $display("FAIL wrap_up_q[%0d]: got %0d want %0d", i, q, up_exp[i]); end
      n_cmp++; if (tc !== (i == 9)) begin n_fail++; $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, tc, (i == 9)); end
    end
    n_cmp++; if (state !== S_UP || dir !== 1'b1) begin n_fail++; $display("FAIL wrap_up_state: got st=%0d dir=%b want st=%0d dir=1", state, dir, S_UP); end
  endtask

  task automatic test_wrap_down();
    clear = 1'b1;
    tick();
    n_cmp++; if (q !== 4'd0 || state !== S_IDLE) begin n_fail++; $display("FAIL clear: got q=%0d st=%0d want q=0 st=0", q, state); end
    clear = 1'b0; up_down = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd9 || tc !== 1'b1) begin n_fail++; $display("FAIL wrap_down_0: got q=%0d tc=%b want q=9 tc=1", q, tc); end
    tick();
    n_cmp++; if (q !== 4'd8 || tc !== 1'b0) begin n_fail++; $display("FAIL wrap_down_1: got q=%0d tc=%b want q=8 tc=0", q, tc); end
    tick();
    n_cmp++; if (q !== 4'd7 || tc !== 1'b0 || dir !== 1'b0 || state !== S_DOWN) begin n_fail++; $display("FAIL wrap_down_2: got q=%0d tc=%b dir=%b st=%0d want q=7 tc=0 dir=0 st=2", q, tc, dir, state); end
  endtask

  task automatic test_saturate();
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    n_cmp++; if (q !== 4'd7 || state !== S_IDLE) begin n_fail++; $display("FAIL sat_load: got q=%0d st=%0d want q=7 st=0", q, state); end
    load = 1'b0; en = 1'b1; up_down = 1'b1; mode = MODE_SAT;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (q !== sat_q_exp[i] || sat !== sat_f_exp[i] || tc !== 1'b0) begin n_fail++; $display("FAIL sat_up[%0d]: got q=%0d sat=%b tc=%b want q=%0d sat=%b tc=0", i, q, sat, tc, sat_q_exp[i], sat_f_exp[i]); end
    end
    n_cmp++; if (state !== S_SAT_HI) begin n_fail++; $display("FAIL sat_state_hi: got %0d want %0d", state, S_SAT_HI); end
    en = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd9 || state !== S_SAT_HI || sat !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got q=%0d st=%0d sat=%b want q=9 st=3 sat=1", q, state, sat); end
    en = 1'b1; up_down = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd8 || sat !== 1'b0 || state !== S_DOWN) begin n_fail++; $display("FAIL sat_leave: got q=%0d sat=%b st=%0d want q=8 sat=0 st=2", q, sat, state); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd0 || state !== S_SAT_LO || sat !== 1'b1 || tc !== 1'b0) begin n_fail++; $display("FAIL sat_lo: got q=%0d st=%0d sat=%b tc=%b want q=0 st=4 sat=1 tc=0", q, state, sat, tc); end
  endtask

  task automatic test_load_clamp();
    mode = MODE_WRAP; en = 1'b0; load = 1'b1; load_val = 4'd13; max_v = 4'd9;
    tick();
    n_cmp++; if (q !== 4'd9 || state !== S_IDLE || sat !== 1'b0) begin n_fail++; $display("FAIL load_clamp: got q=%0d st=%0d sat=%b want q=9 st=0 sat=0", q, state, sat); end
    load = 1'b0; max_v = 4'd5; en = 1'b1; up_down = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd5 || tc !== 1'b0 || state !== S_DOWN) begin n_fail++; $display("FAIL max_lowered: got q=%0d tc=%b st=%0d want q=5 tc=0 st=2", q, tc, state); end
    clear = 1'b1; load = 1'b1; load_val = 4'd3;
    tick();
    n_cmp++; if (q !== 4'd0 || state !== S_IDLE || tc !== 1'b0) begin n_fail++; $display("FAIL clear_load_en: got q=%0d st=%0d tc=%b want q=0 st=0 tc=0", q, state, tc); end
    clear = 1'b0; up_down = 1'b1;
    tick();
    n_cmp++; if (q !== 4'd3 || state !== S_IDLE) begin n_fail++; $display("FAIL load_en: got q=%0d st=%0d want q=3 st=0", q, state); end
    load = 1'b0;
  endtask

  task automatic test_mode_change();
    max_v = 4'd9; en = 1'b0; load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1; mode = MODE_SAT;
    tick();
    n_cmp++; if (q !== 4'd9 || state !== S_SAT_HI) begin n_fail++; $display("FAIL mode_sat: got q=%0d st=%0d want q=9 st=3", q, state); end
    mode = MODE_WRAP;
    tick();
    n_cmp++; if (q !== 4'd0 || tc !== 1'b1 || sat !== 1'b0 || state !== S_UP) begin n_fail++; $display("FAIL mode_to_wrap: got q=%0d tc=%b sat=%b st=%0d want q=0 tc=1 sat=0 st=1", q, tc, sat, state); end
  endtask

  task automatic test_async_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1; up_down = 1'b1; mode = MODE_WRAP; max_v = 4'd9;
    repeat (6) tick();
    n_cmp++; if (q !== 4'd6) begin n_fail++; $display("FAIL pre_reset_q: got %0d want 6", q); end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (q !== 4'd0 || {tc, sat, dir} !== 3'b001 || state !== S_IDLE) begin n_fail++; $display("FAIL async_reset: got q=%0d tc/sat/dir=%b st=%0d want q=0 001 st=0", q, {tc, sat, dir}, state); end
    tick();
    n_cmp++; if (q !== 4'd0) begin n_fail++; $display("FAIL reset_held: got %0d want 0", q); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (q !== 4'd1) begin n_fail++; $display("FAIL resume_0: got %0d want 1", q); end
    tick();
    n_cmp++; if (q !== 4'd2) begin n_fail++; $display("FAIL resume_1: got %0d want 2", q); end
  endtask

  task automatic test_full_range();
    max_v = 4'd15; en = 1'b0; load = 1'b1; load_val = 4'd14;
    tick();
    load = 1'b0; en = 1'b1; up_down = 1'b1;
    tick();
    n_cmp++; if (q !== 4'd15 || tc !== 1'b0) begin n_fail++; $display("FAIL full_up_15: got q=%0d tc=%b want q=15 tc=0", q, tc); end
    tick();
    n_cmp++; if (q !== 4'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL full_wrap_up: got q=%0d tc=%b want q=0 tc=1", q, tc); end
    up_down = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd15 || tc !== 1'b1) begin n_fail++; $display("FAIL full_wrap_down: got q=%0d tc=%b want q=15 tc=1", q, tc); end
    en = 1'b0;
    tick();
    n_cmp++; if (q !== 4'd15 || tc !== 1'b0 || state !== S_IDLE) begin n_fail++; $display("FAIL hold_idle: got q=%0d tc=%b st=%0d want q=15 tc=0 st=0", q, tc, state); end
  endtask

  task automatic test_back_to_back();
    max_v = 4'd1; clear = 1'b1;
    tick();
    clear = 1'b0; en = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (q !== ((i % 2 == 0) ? 4'd1 : 4'd0) || tc !== (i % 2 == 1)) begin n_fail++; $display("FAIL b2b_up[%0d]: got q=%0d tc=%b", i, q, tc); end
    end
    up_down = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (q !== ((i == 0) ? 4'd1 : 4'd0) || tc !== (i == 0)) begin n_fail++; $display("FAIL b2b_down[%0d]: got q=%0d tc=%b", i, q, tc); end
    end
    max_v = 4'd0; up_down = 1'b1;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    n_cmp++; if (q !== 4'd0 || state !== S_IDLE || tc !== 1'b0) begin n_fail++; $display("FAIL max0_recover: got q=%0d st=%0d tc=%b want q=0 st=0 tc=0", q, state, tc); end
    clear = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_load_clamp();
    test_mode_change();
    test_async_reset();
    test_full_range();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_n_updown_counter.md
# mod_n_updown_counter

Parametrised modulo-N up/down counter with a runtime-programmable terminal value, synchronous clear and load, and selectable wrap or saturate behaviour. It is the next-generation replacement for the fixed-modulus FSM counter and is used wherever a scalable event/sequence counter with status flags is needed. An explicit state machine tracks the counting mode. The block emits a registered terminal-count pulse and a saturation flag for cascading and control.

## Interface
- WIDTH, 4, counter and terminal-value width in bits (≥2)
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_clear  input  1  synchronous clear, highest priority
- i_load  input  1  synchronous load of i_load_val
- i_load_val  input  WIDTH  value to load
- i_en  input  1  count enable
- i_up_down  input  1  1 = count up, 0 = count down
- i_mode  input  1  0 = wrap, 1 = saturate
- i_max  input  WIDTH  terminal value (modulus − 1), legal ≥1
- o_Q  output  WIDTH  current count
- o_tc  output  1  one-cycle pulse, wrap occurred at the last edge
- o_sat  output  1  level, counter clamped at a bound
- o_dir  output  1  direction of the last count (1 = up)

## Operation
- Per-edge priority: i_clear > i_load > i_en count > hold.
- FSM states: S_IDLE, S_UP, S_DOWN, S_SAT_HI, S_SAT_LO.
- Clear:
  - o_Q←0, state←S_IDLE, o_tc←0.
- Load:
  - o_Q←min(i_load_val, i_max), state←S_IDLE, o_tc←0.
- i_en=0 with no clear/load:
  - o_Q holds.
  - S_UP/S_DOWN→S_IDLE.
  - S_SAT_* states hold.
- Count up, o_Q < i_max:
  - o_Q+1, state←S_UP, o_dir←1.
- Count up, o_Q ≥ i_max:
  - Wrap mode: o_Q←0, o_tc←1, state←S_UP.
  - Saturate mode: o_Q←i_max, state←S_SAT_HI, o_tc←0.
- Count down, 0 < o_Q ≤ i_max:
  - o_Q−1, state←S_DOWN, o_dir←0.
- Count down, o_Q = 0:
  - Wrap mode: o_Q←i_max, o_tc←1, state←S_DOWN.
  - Saturate mode: hold 0, state←S_SAT_LO.
- Count down, o_Q > i_max (i_max lowered at runtime):
  - o_Q←i_max, no o_tc, state←S_DOWN.
- Leaving S_SAT_HI/S_SAT_LO:
  - Any clear, load, or count in the opposite direction leaves saturation.
  - A count in the opposite direction enters S_UP/S_DOWN with the normal step.
- o_sat = (state ∈ {S_SAT_HI, S_SAT_LO}).
- i_mode and i_max are sampled every edge.
  - A mode change takes effect on the next count.
  - A change while saturated with i_mode=0 makes the next same-direction count wrap.
- Arithmetic is unsigned WIDTH-bit with no intermediate overflow.
  - i_max = 2^WIDTH−1 gives full-range counting.
  - i_max = 0 is illegal; the behaviour is undefined but must not lock up, and the next clear recovers.
- Illegal state encodings → S_IDLE, o_Q unchanged.

## Timing
- All outputs are registered. o_Q, o_tc and o_sat update on the same edge.
- Latency from an input to its effect on o_Q is one cycle.
- o_tc is high for exactly one cycle per wrap; back-to-back wraps (i_max=1 … i_max small) give consecutive pulses as applicable.
- Reset (i_rst_n low, asynchronous, any time including mid-count):
  - o_Q=0, o_tc=0, o_sat=0, o_dir=1, state=S_IDLE.
  - The first count is allowed on the first rising edge after deassertion.
- Simultaneous clear+load+en: clear wins. Simultaneous load+en: load wins, with no count that cycle.

## Structure
- Package mod_n_counter_pkg holds:
  - state enum typedef (3-bit) with S_* encodings
  - mode constants MODE_WRAP=0, MODE_SAT=1
- Sub-module mod_n_step is combinational. It takes o_Q, i_max, i_up_down and i_mode, and returns the next value, a wrap flag and a clamp flag.
- The top holds the FSM and the output registers.

## Test plan
- WIDTH=4, i_max=9, wrap mode, i_up_down=1, 12 cycles from reset:
  - o_Q = 1…9, 0, 1, 2.
  - o_tc high only in the cycle o_Q=0 first appears.
- Wrap mode, i_up_down=0 from 0, i_max=9:
  - o_Q = 9, 8, 7.
  - o_tc pulse with the 9.
- Saturate mode, count up from 7 with i_max=9:
  - o_Q = 8, 9, 9, 9; o_sat rises with the second 9, o_tc never.
  - Then i_up_down=0 gives 8 and o_sat=0.
- Load 13 with i_max=9: o_Q=9.
  - Then i_max=5 and count down: o_Q=5, no o_tc.
  - Then clear+load+en together: o_Q=0, state S_IDLE.
- Assert i_rst_n low mid-count at o_Q=6 between edges: outputs go to 0 immediately, and counting resumes 1, 2 after release.
- i_max=15 (full range), up count through 15: 15→0 wrap with o_tc; down from 0 gives 15 with o_tc.
